// File: rtl/ysyx_24100006_pipe_pkg.sv
// Decode-bundle layout shared by the ID/EXE boundary, plus small helper types.
// Fields are listed MSB-first in the same order as the IDU concatenation.
package ysyx_24100006_pipe_pkg;

  localparam int PAYLOAD_W = 217;

  localparam int PC_W        = 32;
  localparam int IMM_W       = 32;
  localparam int RS1_W       = 32;
  localparam int RS2_W       = 32;
  localparam int CSR_RDATA_W = 32;
  localparam int ALUOP_W     = 5;
  localparam int ALUSRCA_W   = 2;
  localparam int ALUSRCB_W   = 2;
  localparam int GPR_WADDR_W = 4;
  localparam int CSR_WADDR_W = 12;
  localparam int RDSEL_W     = 2;
  localparam int JUMP_W      = 2;
  localparam int WMASK_W     = 4;
  localparam int RMASK_W     = 4;
  localparam int SRW_W       = 2;
  localparam int IRQ_NO_W    = 13;

  localparam int IS_BREAK_O  = 0;
  localparam int IRQ_NO_O    = 1;
  localparam int IRQ_O       = 14;
  localparam int FENCE_I_O   = 15;
  localparam int SRW_O       = 16;
  localparam int RMASK_O     = 18;
  localparam int WMASK_O     = 22;
  localparam int JUMP_O      = 26;
  localparam int RDSEL_O     = 28;
  localparam int CSR_WADDR_O = 30;
  localparam int GPR_WADDR_O = 42;
  localparam int CSR_WEN_O   = 46;
  localparam int GPR_WEN_O   = 47;
  localparam int ALUSRCB_O   = 48;
  localparam int ALUSRCA_O   = 50;
  localparam int ALUOP_O     = 52;
  localparam int CSR_RDATA_O = 57;
  localparam int RS2_O       = 89;
  localparam int RS1_O       = 121;
  localparam int IMM_O       = 153;
  localparam int PC_O        = 185;

  typedef enum logic [1:0] {
    SRW_NONE  = 2'b00,
    SRW_READ  = 2'b01,
    SRW_WRITE = 2'b10
  } srw_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  function automatic logic srw_is_read(input logic [SRW_W-1:0] srw);
    return srw == SRW_READ;
  endfunction

endpackage

// File: rtl/ysyx_24100006_skid_buf.sv
// Generic 2-entry skid buffer with flush; 1-cycle latency when empty.
// in_ready is a pure function of the state register, so upstream never sees out_ready combinationally.
module ysyx_24100006_skid_buf
  import ysyx_24100006_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q;
  logic         ld_main_in, ld_main_skid, ld_skid;
  logic         in_fire, out_fire;

  assign in_ready_o  = (state_q != SKID_FULL);
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_d    = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_d = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_d      = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush wins over everything; payload regs keep stale data behind valid=0.
    if (flush_i) begin
      state_d      = SKID_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
    main_d = ld_main_skid ? skid_q : in_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_in || ld_main_skid) main_q <= main_d;
      if (ld_skid)                    skid_q <= in_data_i;
    end
  end

endmodule

// File: rtl/ysyx_24100006_id_exe_reg.sv
// ID->EXE pipeline register: skid buffer plus hazard export and stall counter; 1-cycle latency.
// Holds the head while EXE stalls; IDU ready is register-driven and drops only when both entries fill.
module ysyx_24100006_id_exe_reg
  import ysyx_24100006_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = ysyx_24100006_pipe_pkg::PAYLOAD_W,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush,
  output logic [3:0]           ex_rd_addr,
  output logic                 ex_gpr_write,
  output logic                 ex_is_load,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ysyx_24100006_skid_buf #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_payload)
  );

  // Only the head is exported: a skid entry implies the IDU is already blocked.
  assign ex_rd_addr   = out_valid ? out_payload[GPR_WADDR_O +: GPR_WADDR_W] : '0;
  assign ex_gpr_write = out_valid && out_payload[GPR_WEN_O];
  assign ex_is_load   = out_valid && srw_is_read(out_payload[SRW_O +: SRW_W]);

  assign stall_cnt_d = stall_cnt_q + CNT_W'(1);
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_id_exe_reg.sv
// Directed and randomized checks of the ID/EXE register against a queue-based reference model.
module tb_ysyx_24100006_id_exe_reg;
  import ysyx_24100006_pipe_pkg::*;

  localparam int PW = PAYLOAD_W;
  localparam int CW = 32;
  typedef logic [PW-1:0] pay_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  pay_t          in_payload = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  pay_t          out_payload;
  logic          flush = 1'b0;
  logic [3:0]    ex_rd_addr;
  logic          ex_gpr_write;
  logic          ex_is_load;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ysyx_24100006_id_exe_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .flush       (flush),
    .ex_rd_addr  (ex_rd_addr),
    .ex_gpr_write(ex_gpr_write),
    .ex_is_load  (ex_is_load),
    .stall_cnt   (stall_cnt)
  );

  int            checks = 0;
  int            errors = 0;
  pay_t          q[$];
  logic [31:0]   pcs_out[$];
  logic [CW-1:0] scnt = '0;
  bit            last_in_fire = 1'b0;

  task automatic chk(input string tag, input pay_t act, input pay_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic pay_t rnd_pay();
    pay_t p = '0;
    for (int i = 0; i < 7; i++) p = (p << 32) | PW'($urandom);
    return p;
  endfunction

  function automatic pay_t mk(input logic [31:0] pc, input logic [1:0] srw,
                              input logic gwen, input logic [3:0] rd);
    pay_t p = rnd_pay();
    p[PC_O +: PC_W]               = pc;
    p[SRW_O +: SRW_W]             = srw;
    p[GPR_WEN_O]                  = gwen;
    p[GPR_WADDR_O +: GPR_WADDR_W] = rd;
    return p;
  endfunction

  // One clock: compare DUT against the model at negedge, advance the model, return at posedge+1.
  task automatic step();
    bit   exp_ov, exp_ir, fire_out, fire_in;
    pay_t head;
    @(negedge clk);
    exp_ov = (q.size() != 0);
    exp_ir = (q.size() < 2);
    head   = exp_ov ? q[0] : '0;
    chk("out_valid", PW'(out_valid), PW'(exp_ov));
    chk("in_ready", PW'(in_ready), PW'(exp_ir));
    chk("stall_cnt", PW'(stall_cnt), PW'(scnt));
    if (exp_ov) chk("out_payload", out_payload, head);
    chk("ex_gpr_write", PW'(ex_gpr_write), PW'(exp_ov && head[GPR_WEN_O]));
    chk("ex_is_load", PW'(ex_is_load), PW'(exp_ov && head[SRW_O +: 2] == 2'b01));
    chk("ex_rd_addr", PW'(ex_rd_addr), exp_ov ? PW'(head[GPR_WADDR_O +: 4]) : '0);
    fire_out = exp_ov && out_ready;
    fire_in  = in_valid && exp_ir;
    last_in_fire = fire_in && !flush;
    if (exp_ov && !out_ready) scnt = scnt + 1;
    if (flush) begin
      q.delete();
    end else begin
      if (fire_out) begin
        pcs_out.push_back(q[0][PC_O +: 32]);
        void'(q.pop_front());
      end
      if (fire_in) q.push_back(in_payload);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_in_ready", PW'(in_ready), PW'(1'b1));
    chk("rst_stall_cnt", PW'(stall_cnt), '0);
    chk("rst_ex_gpr_write", PW'(ex_gpr_write), '0);
    chk("rst_ex_is_load", PW'(ex_is_load), '0);
    q.delete();
    pcs_out.delete();
    scnt = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Reset asserted while FULL with a nonzero stall count.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_payload = mk(32'h1000, 2'b00, 1'b0, 4'd0); step();
    in_payload = mk(32'h1004, 2'b00, 1'b0, 4'd0); step();
    step();
    chk("t1_full_in_ready", PW'(in_ready), '0);
    do_reset();

    // Back-to-back streaming.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_payload = mk(32'h8000_0000 + 32'(4 * i), 2'b00, 1'b1, 4'(i));
      step();
      chk("t2_pc_lat1", PW'(out_payload[PC_O +: 32]), PW'(32'h8000_0000 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    step(); step();
    chk("t2_count", PW'(pcs_out.size()), PW'(3));
    for (int i = 0; i < pcs_out.size() && i < 3; i++)
      chk("t2_order", PW'(pcs_out[i]), PW'(32'h8000_0000 + 32'(4 * i)));

    // Three-cycle stall with A, B, C offered.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_payload = mk(32'hA, 2'b00, 1'b0, 4'd1); step();
    in_payload = mk(32'hB, 2'b00, 1'b0, 4'd2); step();
    chk("t3_in_ready_full", PW'(in_ready), '0);
    in_payload = mk(32'hC, 2'b00, 1'b0, 4'd3); step();
    step();
    chk("t3_stall_cnt", PW'(stall_cnt), PW'(3));
    out_ready = 1'b1;
    for (int i = 0; i < 12 && (in_valid || q.size() != 0); i++) begin
      step();
      if (last_in_fire) in_valid = 1'b0;
    end
    chk("t3_count", PW'(pcs_out.size()), PW'(3));
    for (int i = 0; i < pcs_out.size() && i < 3; i++)
      chk("t3_order", PW'(pcs_out[i]), PW'(32'hA + 32'(i)));
    chk("t3_stall_final", PW'(stall_cnt), PW'(3));

    // Flush while FULL drops the offered input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_payload = mk(32'h2000, 2'b00, 1'b0, 4'd0); step();
    in_payload = mk(32'h2004, 2'b00, 1'b0, 4'd0); step();
    in_payload = mk(32'h2008, 2'b00, 1'b0, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_out_valid", PW'(out_valid), '0);
    chk("t4_in_ready", PW'(in_ready), PW'(1'b1));
    step();
    chk("t4_still_empty", PW'(out_valid), '0);

    // Load at head exported to hazard unit.
    in_valid = 1'b1;
    in_payload = mk(32'h3000, 2'b01, 1'b1, 4'd5);
    step();
    in_valid = 1'b0;
    chk("t5_is_load", PW'(ex_is_load), PW'(1'b1));
    chk("t5_gpr_write", PW'(ex_gpr_write), PW'(1'b1));
    chk("t5_rd_addr", PW'(ex_rd_addr), PW'(5));
    out_ready = 1'b1;
    step();
    chk("t5_is_load_gone", PW'(ex_is_load), '0);
    chk("t5_gpr_write_gone", PW'(ex_gpr_write), '0);

    // Randomized traffic; IDU holds its payload until accepted.
    in_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || last_in_fire) in_payload = rnd_pay();
      if (!in_valid || last_in_fire) in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
